// File: rtl/smg_pkg.sv
// Shared definitions for the 7-segment BCD converter: state encoding,
// digit codes and the leading-zero blanking helper.
package smg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1
  } state_t;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] BCD_ADJ_TH  = 4'd5;
  localparam int         BCD_DIGITS  = 4;

  // Replace leading zero digits (thousands downwards) by the blank code;
  // the units digit is always kept so that zero still shows as "0".
  function automatic logic [15:0] blank_leading_zeros(input logic [15:0] bcd);
    logic [15:0] res;
    logic        lead;
    res  = bcd;
    lead = 1'b1;
    for (int i = BCD_DIGITS - 1; i > 0; i--) begin
      if (lead && (bcd[i*4 +: 4] == 4'd0)) begin
        res[i*4 +: 4] = DIGIT_BLANK;
      end else begin
        lead = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/smg_bcd_adjust.sv
// Single-digit add-3 correction used by the double-dabble shifter.
module smg_bcd_adjust
  import smg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= BCD_ADJ_TH) ? (digit + 4'd3) : digit;

endmodule

// File: rtl/smg_bcd_convert_module.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble).
// Optional build macro SMG_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module smg_bcd_convert_module
  import smg_pkg::*;
#(
  parameter int                 BIN_W   = 14,
  parameter logic [BIN_W-1:0]   MAX_VAL = 14'd9999
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [BIN_W-1:0] Bin_Data,
  input  logic             Start_Sig,
  output logic             Busy_Sig,
  output logic             Done_Sig,
  output logic             Overflow_Sig,
  output logic [15:0]      Number_Sig
);

  localparam int                BCD_W    = BCD_DIGITS * 4;
  localparam int                CNT_W    = $clog2(BIN_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BIN_W - 1);

  state_t             state_r, state_nxt;
  logic [CNT_W-1:0]   cnt_r, cnt_nxt;
  logic [BIN_W-1:0]   bin_r, bin_nxt;
  logic [BCD_W-1:0]   bcd_r, bcd_nxt;
  logic               ovf_r, ovf_nxt;
  logic               busy_r, busy_nxt;
  logic               done_r, done_nxt;
  logic               ovf_out_r, ovf_out_nxt;
  logic [BCD_W-1:0]   number_r, number_nxt;

  logic [BCD_W-1:0]       adj_s;
  logic [BCD_W+BIN_W-1:0] shifted_s;
  logic [BCD_W-1:0]       final_s;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
    smg_bcd_adjust u_adj (
      .digit    (bcd_r[g*4 +: 4]),
      .adjusted (adj_s[g*4 +: 4])
    );
  end

  assign shifted_s = {adj_s, bin_r} << 1;

`ifdef SMG_LEADING_ZERO_BLANK_EN
  assign final_s = blank_leading_zeros(shifted_s[BCD_W+BIN_W-1 -: BCD_W]);
`else
  assign final_s = shifted_s[BCD_W+BIN_W-1 -: BCD_W];
`endif

  // Next-state and next-output computation for the converter FSM.
  always_comb begin
    state_nxt   = state_r;
    cnt_nxt     = cnt_r;
    bin_nxt     = bin_r;
    bcd_nxt     = bcd_r;
    ovf_nxt     = ovf_r;
    busy_nxt    = busy_r;
    done_nxt    = 1'b0;
    ovf_out_nxt = ovf_out_r;
    number_nxt  = number_r;
    case (state_r)
      ST_IDLE: begin
        if (Start_Sig) begin
          if (Bin_Data > MAX_VAL) begin
            bin_nxt = MAX_VAL;
            ovf_nxt = 1'b1;
          end else begin
            bin_nxt = Bin_Data;
            ovf_nxt = 1'b0;
          end
          bcd_nxt   = {BCD_W{1'b0}};
          cnt_nxt   = {CNT_W{1'b0}};
          busy_nxt  = 1'b1;
          state_nxt = ST_SHIFT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        bcd_nxt = shifted_s[BCD_W+BIN_W-1 -: BCD_W];
        bin_nxt = shifted_s[BIN_W-1:0];
        cnt_nxt = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_r == LAST_CNT) begin
          // Outputs update only here, so the scanner never sees partial digits.
          number_nxt  = final_s;
          ovf_out_nxt = ovf_r;
          done_nxt    = 1'b1;
          busy_nxt    = 1'b0;
          state_nxt   = ST_IDLE;
        end else begin
          state_nxt = ST_SHIFT;
        end
      end
      default: begin
        busy_nxt  = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_r   <= ST_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      bin_r     <= {BIN_W{1'b0}};
      bcd_r     <= {BCD_W{1'b0}};
      ovf_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_out_r <= 1'b0;
      number_r  <= {BCD_W{1'b0}};
    end else begin
      state_r   <= state_nxt;
      cnt_r     <= cnt_nxt;
      bin_r     <= bin_nxt;
      bcd_r     <= bcd_nxt;
      ovf_r     <= ovf_nxt;
      busy_r    <= busy_nxt;
      done_r    <= done_nxt;
      ovf_out_r <= ovf_out_nxt;
      number_r  <= number_nxt;
    end
  end

  assign Busy_Sig     = busy_r;
  assign Done_Sig     = done_r;
  assign Overflow_Sig = ovf_out_r;
  assign Number_Sig   = number_r;

endmodule
